// File: rtl/img_ring_fetch.sv
// img_ring_fetch: fetches a center pixel and its 16-pixel radius-3 ring from an image SRAM
// ports: ramclk/rst clock and sync reset; start,cx,cy request a fetch around (cx,cy);
//        busy,done status; x_addr,y_addr,ren,wen,wdat drive the SRAM, rdat returns one cycle after ren;
//        center_px and ring_px (slot i at [i*PIXEL_DEPTH +: PIXEL_DEPTH]) hold the results from done on
module img_ring_fetch #(
  parameter int PIXEL_DEPTH = 8,
  parameter int X_MAX = 16,
  parameter int Y_MAX = 16,
  localparam int XW = $clog2(X_MAX),
  localparam int YW = $clog2(Y_MAX)
) (
  input  logic                      ramclk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [XW-1:0]             cx,
  input  logic [YW-1:0]             cy,
  output logic                      busy,
  output logic                      done,
  output logic [XW-1:0]             x_addr,
  output logic [YW-1:0]             y_addr,
  output logic                      ren,
  output logic                      wen,
  output logic [PIXEL_DEPTH-1:0]    wdat,
  input  logic [PIXEL_DEPTH-1:0]    rdat,
  output logic [PIXEL_DEPTH-1:0]    center_px,
  output logic [16*PIXEL_DEPTH-1:0] ring_px
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  // ring offsets as 4-bit two's complement, slot 15 first
  localparam logic [15:0][3:0] DX = {4'hf, 4'he, 4'hd, 4'hd, 4'hd, 4'he, 4'hf, 4'h0,
                                     4'h1, 4'h2, 4'h3, 4'h3, 4'h3, 4'h2, 4'h1, 4'h0};
  localparam logic [15:0][3:0] DY = {4'hd, 4'he, 4'hf, 4'h0, 4'h1, 4'h2, 4'h3, 4'h3,
                                     4'h3, 4'h2, 4'h1, 4'h0, 4'hf, 4'he, 4'hd, 4'hd};
  localparam logic [XW+1:0] XLIM = (XW+2)'(X_MAX);
  localparam logic [YW+1:0] YLIM = (YW+2)'(Y_MAX);
  state_t state_q, state_d;
  logic [4:0] k_q, k_d, tag_k_q;
  logic [XW-1:0] cx_q;
  logic [YW-1:0] cy_q;
  logic tag_v_q, tag_ib_q, fetching, in_bounds;
  logic [PIXEL_DEPTH-1:0] center_q;
  logic [15:0][PIXEL_DEPTH-1:0] ring_q;
  logic [3:0] ri, dx, dy;
  logic [XW+1:0] px;
  logic [YW+1:0] py;
  always_comb begin
    ri = k_q[3:0] - 4'd1;
    dx = (k_q == 5'd0) ? 4'd0 : DX[ri];
    dy = (k_q == 5'd0) ? 4'd0 : DY[ri];
    // two guard bits: the msb flags a negative coordinate, the next absorbs +3 overflow
    px = {2'b00, cx_q} + {{(XW-2){dx[3]}}, dx};
    py = {2'b00, cy_q} + {{(YW-2){dy[3]}}, dy};
    fetching = state_q == FETCH;
    in_bounds = !px[XW+1] && !py[YW+1] && (px < XLIM) && (py < YLIM);
    ren = fetching && in_bounds;
    x_addr = ren ? px[XW-1:0] : '0;
    y_addr = ren ? py[YW-1:0] : '0;
    state_d = (state_q == IDLE)  ? (start ? FETCH : IDLE) :
              (state_q == FETCH) ? ((k_q == 5'd16) ? DRAIN : FETCH) :
              (state_q == DRAIN) ? DONE : IDLE;
    k_d = fetching ? k_q + 5'd1 : 5'd0;
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign wen = 1'b0;
  assign wdat = '0;
  assign center_px = center_q;
  assign ring_px = ring_q;
  always_ff @(posedge ramclk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      tag_v_q <= 1'b0;
      tag_ib_q <= 1'b0;
      tag_k_q <= '0;
      center_q <= '0;
      ring_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      if (state_q == IDLE && start) begin
        cx_q <= cx;
        cy_q <= cy;
      end
      tag_v_q <= fetching;
      tag_ib_q <= ren;
      tag_k_q <= k_q;
      // the tag lines up with rdat for the point issued on the previous cycle
      if (tag_v_q && tag_k_q == 5'd0) center_q <= tag_ib_q ? rdat : '0;
      if (tag_v_q && tag_k_q != 5'd0) ring_q[tag_k_q[3:0] - 4'd1] <= tag_ib_q ? rdat : '0;
    end
  end
endmodule

// File: doc/img_ring_fetch.md
IMG_RING_FETCH -- requirements
Module: img_ring_fetch

Interface
REQ-001 The block SHALL have parameter PIXEL_DEPTH, default 8, giving the bits per pixel.
REQ-002 The block SHALL have parameter X_MAX, default 16, giving the image width in pixels.
REQ-003 The block SHALL have parameter Y_MAX, default 16, giving the image height in pixels.
REQ-004 The block SHALL have port ramclk, input, width 1: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, width 1: synchronous active-high reset.
REQ-006 The block SHALL have port start, input, width 1: request a fetch, sampled only in IDLE.
REQ-007 The block SHALL have port cx, input, width $clog2(X_MAX): center x.
REQ-008 The block SHALL have port cy, input, width $clog2(Y_MAX): center y.
REQ-009 The block SHALL have port busy, output, width 1: high in every state except IDLE.
REQ-010 The block SHALL have port done, output, width 1: one-cycle pulse; results valid.
REQ-011 The block SHALL have port x_addr, output, width $clog2(X_MAX): image SRAM column address.
REQ-012 The block SHALL have port y_addr, output, width $clog2(Y_MAX): image SRAM row address.
REQ-013 The block SHALL have port ren, output, width 1: image SRAM read enable.
REQ-014 The block SHALL have port wen, output, width 1: tied 0.
REQ-015 The block SHALL have port wdat, output, width PIXEL_DEPTH: tied 0.
REQ-016 The block SHALL have port rdat, input, width PIXEL_DEPTH: SRAM read data, valid one cycle after ren.
REQ-017 The block SHALL have port center_px, output, width PIXEL_DEPTH: fetched center pixel.
REQ-018 The block SHALL have port ring_px, output, width 16*PIXEL_DEPTH: ring pixel i at bits [i*PIXEL_DEPTH +: PIXEL_DEPTH].

Function
REQ-019 The block SHALL implement states IDLE, FETCH, DRAIN and DONE.
REQ-020 In IDLE, start=1 SHALL latch cx/cy into internal registers and enter FETCH with index k=0.
REQ-021 The fetch order SHALL be k=0 for the center (0,0), then k=1..16 for ring i=k-1 at offsets (dx,dy): (0,-3),(1,-3),(2,-2),(3,-1),(3,0),(3,1),(2,2),(1,3),(0,3),(-1,3),(-2,2),(-3,1),(-3,0),(-3,-1),(-2,-2),(-1,-3).
REQ-022 Coordinates SHALL be computed signed at width $clog2(MAX)+2; a point is out of bounds if px<0, px>=X_MAX, py<0 or py>=Y_MAX.
REQ-023 In FETCH, each cycle SHALL present point k: ren=1 with x_addr/y_addr = px/py if in bounds; otherwise ren=0 and x_addr=y_addr=0.
REQ-024 FETCH SHALL last exactly 17 cycles (k=0..16), then go to DRAIN for 1 cycle, then DONE for 1 cycle, then IDLE.
REQ-025 A registered valid/in-bounds/index tag SHALL follow each issue by one cycle; on the following cycle the block SHALL store rdat into that slot if the point was in bounds, else 0.
REQ-026 rdat SHALL be ignored in any cycle not following an in-bounds issue.
REQ-027 done SHALL be high only in DONE, i.e. exactly one cycle, 18 edges after the edge that sampled start.
REQ-028 center_px and ring_px SHALL hold their values from DONE until the next accepted start; slots are overwritten during the next fetch.
REQ-029 start SHALL be ignored outside IDLE, and a cx/cy change after acceptance SHALL have no effect.
REQ-030 Outside FETCH, ren SHALL be 0 and x_addr/y_addr SHALL be 0.
REQ-031 A center input outside the image (cx>=X_MAX or cy>=Y_MAX) SHALL be handled by the same bounds rule, with no special case.

Reset
REQ-032 On rst=1 at a clock edge, the block SHALL enter IDLE and clear busy, done, ren, x_addr, y_addr, center_px, ring_px, the index and the pipeline tag to 0.
REQ-033 rst SHALL take priority over start and over an in-progress fetch; a fetch aborted by reset SHALL NOT produce done.

Verification
REQ-034 Center in image: model with X_MAX=Y_MAX=16 holding pixel=x+16*y, start with (8,8) -> 17 ren pulses, done at edge 18, center_px=0x88, ring[0]=0x58, ring[4]=0x8B, ring[12]=0x85.
REQ-035 Corner: start at (0,0) -> exactly 6 ren pulses, center_px=0x00, ring[0]=0, ring[4]=0x03, ring[6]=0x22, ring[12]=0.
REQ-036 Far corner: start at (15,15) -> ring[4]=0, ring[12]=0xFC, ring[0]=0xCF, and no address >15 ever presented.
REQ-037 Start while busy: pulse start with (2,2) during FETCH of (8,8) -> ignored, results match (8,8), and exactly one done.
REQ-038 Reset mid-fetch: assert rst at FETCH k=7 -> next cycle IDLE, ren=0, outputs 0, no done; a new start at (8,8) then completes correctly.
REQ-039 Back-to-back: start asserted in the first IDLE cycle after done -> second fetch accepted, with done pulses 20 cycles apart.
